branch_resolve_unit: RTL

BRANCH_RESOLVE_UNIT -- requirements
Module: branch_resolve_unit

---
 rtl/branch_resolve_unit.sv | 137 +++++++++++++
 1 files changed

// File: rtl/branch_resolve_unit.sv
// Branch resolver: registered beq/bne/jump evaluation, with a RUN/FLUSH squash window after taken branches.
// Optional BRANCH_STATS_EN adds saturating branch_count/taken_count ports.
module branch_resolve_unit #(
  parameter int unsigned WIDTH        = 32,
  parameter int unsigned IMM_W        = 16,
  parameter int unsigned SHIFT        = 2,
  parameter int unsigned FLUSH_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic             in_valid,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] pc_plus4,
  input  logic [IMM_W-1:0] imm,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  output logic [WIDTH-1:0] target,
  output logic             out_valid,
  output logic             taken,
  output logic             flush
`ifdef BRANCH_STATS_EN
  ,
  output logic [15:0]      branch_count,
  output logic [15:0]      taken_count
`endif
);

  localparam int unsigned CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  typedef enum logic {RUN, FLUSH} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] target_q, target_d;
  logic             valid_q, valid_d;
  logic             taken_q, taken_d;
  logic             flush_q, flush_d;

  logic [WIDTH-1:0] offset;
  logic [WIDTH-1:0] br_target;
  logic             cond_taken;
  logic             accept;

  assign offset    = WIDTH'($signed(imm)) << SHIFT;
  assign br_target = pc_plus4 + offset;
  assign accept    = in_valid && !stall && (state_q == RUN);

  always_comb begin
    case (op)
      2'b01:   cond_taken = (rs_val == rt_val);
      2'b10:   cond_taken = (rs_val != rt_val);
      2'b11:   cond_taken = 1'b1;
      default: cond_taken = 1'b0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    target_d = target_q;
    valid_d  = valid_q;
    taken_d  = taken_q;
    flush_d  = flush_q;
    if (!stall) begin
      valid_d = 1'b0;
      taken_d = 1'b0;
      case (state_q)
        RUN: begin
          flush_d = 1'b0;
          if (accept) begin
            valid_d  = 1'b1;
            taken_d  = cond_taken;
            target_d = cond_taken ? br_target : pc_plus4;
            flush_d  = cond_taken;
            if (cond_taken) begin
              cnt_d = CNT_W'(FLUSH_CYCLES - 1);
              if (FLUSH_CYCLES > 1) state_d = FLUSH;
            end
          end
        end
        FLUSH: begin
          // flush stays high through the cycle where the counter sits at 0
          if (cnt_q == '0) begin
            state_d = RUN;
            flush_d = 1'b0;
          end else begin
            cnt_d   = cnt_q - 1'b1;
            flush_d = 1'b1;
          end
        end
        default: state_d = RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= RUN;
      cnt_q    <= '0;
      target_q <= '0;
      valid_q  <= 1'b0;
      taken_q  <= 1'b0;
      flush_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      target_q <= target_d;
      valid_q  <= valid_d;
      taken_q  <= taken_d;
      flush_q  <= flush_d;
    end
  end

  assign target    = target_q;
  assign out_valid = valid_q;
  assign taken     = taken_q;
  assign flush     = flush_q;

`ifdef BRANCH_STATS_EN
  logic [15:0] bcnt_q, tcnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bcnt_q <= '0;
      tcnt_q <= '0;
    end else if (accept) begin
      if (op != 2'b00 && bcnt_q != '1) bcnt_q <= bcnt_q + 16'd1;
      if (cond_taken && tcnt_q != '1)  tcnt_q <= tcnt_q + 16'd1;
    end
  end

  assign branch_count = bcnt_q;
  assign taken_count  = tcnt_q;
`endif

endmodule
